// File: rtl/hazard_pkg.sv
`timescale 1ns/1ps
// hazard_pkg: definitions shared by the hazard controller and its comparator.
//   HZ_REG_W  register-index width of the core
//   FWD_*     EX operand-mux select encodings
//   stage_t   destination tracking entry carried down the pipeline (rd, we, ld)
package hazard_pkg;

    localparam int unsigned HZ_REG_W = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;  // register-file read data
    localparam logic [1:0] FWD_MEM = 2'b01;  // ALU result held in MEM
    localparam logic [1:0] FWD_WB  = 2'b10;  // write-back data

    typedef struct packed {
        logic [HZ_REG_W-1:0] rd;
        logic                we;
        logic                ld;
    } stage_t;

endpackage

// File: rtl/fwd_match.sv
`timescale 1ns/1ps
// fwd_match: flags that a pipeline stage produces the register named by idx_i.
//   idx_i    source register index being looked up
//   rd_i     destination index held by the stage
//   we_i     stage writes the register file
//   match_o  stage will supply idx_i; register 0 never matches
module fwd_match
    import hazard_pkg::*;
#(
    parameter int unsigned W = HZ_REG_W
) (
    input  logic [W-1:0] idx_i,
    input  logic [W-1:0] rd_i,
    input  logic         we_i,
    output logic         match_o
);

    assign match_o = we_i && (rd_i != '0) && (rd_i == idx_i);

endmodule

// File: rtl/hazard_ctrl.sv
`timescale 1ns/1ps
// hazard_ctrl: hazard controller for the 5-stage MIPS pipeline.
// Tracks the destination of the instructions in EX, MEM and WB and produces:
//   fwd_a_sel/fwd_b_sel      EX operand mux selects (regfile / MEM / WB)
//   id_wb_byp_a/id_wb_byp_b  ID register read must take the WB write data
//   pc_hold, ifid_hold       freeze fetch during a load-use stall
//   ifid_flush               squash the IF/ID instruction on a taken branch
//   idex_bubble              load a NOP into ID/EX (stall or flush)
//   stall_cnt                saturating count of load-use stall cycles
// Inputs describe the instruction in ID (id_*) plus ex_flush from branch resolution.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W = HZ_REG_W,  // tracking entries assume REG_W == HZ_REG_W
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_we,
    input  logic             id_ld,
    input  logic             ex_flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             id_wb_byp_a,
    output logic             id_wb_byp_b,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_cnt
);

    stage_t           ex_q, ex_d, mem_q, mem_d;
    logic [REG_W-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
    logic [REG_W-1:0] wb_rd_q, wb_rd_d;
    logic             wb_we_q, wb_we_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic mem_a_hit, mem_b_hit, wb_a_hit, wb_b_hit;
    logic byp_a_hit, byp_b_hit, lu_rs_hit, lu_rt_hit;
    logic lu;

    // EX operand lookups
    fwd_match #(.W(REG_W)) u_mem_a (.idx_i(ex_rs_q), .rd_i(mem_q.rd), .we_i(mem_q.we),
                                    .match_o(mem_a_hit));
    fwd_match #(.W(REG_W)) u_mem_b (.idx_i(ex_rt_q), .rd_i(mem_q.rd), .we_i(mem_q.we),
                                    .match_o(mem_b_hit));
    fwd_match #(.W(REG_W)) u_wb_a  (.idx_i(ex_rs_q), .rd_i(wb_rd_q), .we_i(wb_we_q),
                                    .match_o(wb_a_hit));
    fwd_match #(.W(REG_W)) u_wb_b  (.idx_i(ex_rt_q), .rd_i(wb_rd_q), .we_i(wb_we_q),
                                    .match_o(wb_b_hit));

    // ID reads racing the WB register-file write
    fwd_match #(.W(REG_W)) u_byp_a (.idx_i(id_rs), .rd_i(wb_rd_q), .we_i(wb_we_q),
                                    .match_o(byp_a_hit));
    fwd_match #(.W(REG_W)) u_byp_b (.idx_i(id_rt), .rd_i(wb_rd_q), .we_i(wb_we_q),
                                    .match_o(byp_b_hit));

    // Only a load in EX can create a hazard that forwarding cannot cover
    fwd_match #(.W(REG_W)) u_lu_rs (.idx_i(id_rs), .rd_i(ex_q.rd), .we_i(ex_q.we && ex_q.ld),
                                    .match_o(lu_rs_hit));
    fwd_match #(.W(REG_W)) u_lu_rt (.idx_i(id_rt), .rd_i(ex_q.rd), .we_i(ex_q.we && ex_q.ld),
                                    .match_o(lu_rt_hit));

    assign lu = id_valid && ((id_uses_rs && lu_rs_hit) || (id_uses_rt && lu_rt_hit));

    assign id_wb_byp_a = id_valid && id_uses_rs && byp_a_hit;
    assign id_wb_byp_b = id_valid && id_uses_rt && byp_b_hit;
    assign stall_cnt   = stall_cnt_q;

    // Nearest producer wins; a load in MEM never forwards (the stall keeps it from being needed)
    always_comb begin
        fwd_a_sel = FWD_RF;
        fwd_b_sel = FWD_RF;
        if (mem_a_hit && !mem_q.ld) begin
            fwd_a_sel = FWD_MEM;
        end else if (wb_a_hit) begin
            fwd_a_sel = FWD_WB;
        end
        if (mem_b_hit && !mem_q.ld) begin
            fwd_b_sel = FWD_MEM;
        end else if (wb_b_hit) begin
            fwd_b_sel = FWD_WB;
        end
    end

    // A taken branch squashes the dependent instruction, so it overrides the stall
    always_comb begin
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (ex_flush) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (lu) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
        end
    end

    always_comb begin
        ex_d    = '{rd: id_rd, we: id_we, ld: id_ld};
        ex_rs_d = id_rs;
        ex_rt_d = id_rt;
        if (idex_bubble || !id_valid) begin
            ex_d    = '0;
            ex_rs_d = '0;
            ex_rt_d = '0;
        end
        mem_d   = ex_q;
        wb_rd_d = mem_q.rd;
        wb_we_d = mem_q.we;

        stall_cnt_d = stall_cnt_q;
        if (pc_hold && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            mem_q       <= '0;
            wb_rd_q     <= '0;
            wb_we_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            ex_rs_q     <= ex_rs_d;
            ex_rt_q     <= ex_rt_d;
            mem_q       <= mem_d;
            wb_rd_q     <= wb_rd_d;
            wb_we_q     <= wb_we_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
`timescale 1ns/1ps
// tb_hazard_ctrl: directed instruction sequences; each stimulus cycle queues its expected
// outputs and a negedge monitor pops and compares them against the DUT.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int unsigned CW   = 8;  // narrow counter keeps the saturation run short
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid, id_uses_rs, id_uses_rt, id_we, id_ld, ex_flush;
    logic [4:0]    id_rs, id_rt, id_rd;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic          id_wb_byp_a, id_wb_byp_b, pc_hold, ifid_hold, ifid_flush, idex_bubble;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(5), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_we(id_we),
        .id_ld(id_ld), .ex_flush(ex_flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .id_wb_byp_a(id_wb_byp_a), .id_wb_byp_b(id_wb_byp_b), .pc_hold(pc_hold),
        .ifid_hold(ifid_hold), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .stall_cnt(stall_cnt)
    );

    typedef struct packed {
        logic [1:0]    fa;
        logic [1:0]    fb;
        logic          ba, bb, ph, ih, fl, ib;
        logic [CW-1:0] cnt;
    } obs_t;

    obs_t  act;
    obs_t  exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;
    int    cnt_e  = 0;

    assign act = {fwd_a_sel, fwd_b_sel, id_wb_byp_a, id_wb_byp_b, pc_hold, ifid_hold,
                  ifid_flush, idex_bubble, stall_cnt};

    function automatic obs_t mk(input int fa, input int fb, input int ba, input int bb,
                                input int ph, input int ih, input int fl, input int ib);
        obs_t r;
        r.fa  = fa[1:0];
        r.fb  = fb[1:0];
        r.ba  = ba[0];
        r.bb  = bb[0];
        r.ph  = ph[0];
        r.ih  = ih[0];
        r.fl  = fl[0];
        r.ib  = ib[0];
        r.cnt = cnt_e[CW-1:0];
        return r;
    endfunction

    function automatic obs_t zz();
        return mk(0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    // Called #1 after a rising edge; returns #1 after the next one.
    task automatic drive(input string nm, input int v, input int rs, input int rt, input int urs,
                         input int urt, input int rd, input int we, input int ld, input int fl,
                         input obs_t e);
        id_valid   = (v != 0);
        id_rs      = rs[4:0];
        id_rt      = rt[4:0];
        id_uses_rs = (urs != 0);
        id_uses_rt = (urt != 0);
        id_rd      = rd[4:0];
        id_we      = (we != 0);
        id_ld      = (ld != 0);
        ex_flush   = (fl != 0);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input string nm, input obs_t e);
        drive(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, e);
    endtask

    task automatic r3(input string nm, input int rs, input int rt, input int rd, input obs_t e);
        drive(nm, 1, rs, rt, 1, 1, rd, 1, 0, 0, e);
    endtask

    task automatic lw(input string nm, input int base, input int dst, input obs_t e);
        drive(nm, 1, base, dst, 1, 0, dst, 1, 1, 0, e);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) nop("drain", zz());
    endtask

    always @(negedge clk) begin : mon
        obs_t  e;
        string n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got fa=%b fb=%b ba=%b bb=%b ph=%b ih=%b fl=%b ib=%b cnt=%0d, want fa=%b fb=%b ba=%b bb=%b ph=%b ih=%b fl=%b ib=%b cnt=%0d",
                         n, act.fa, act.fb, act.ba, act.bb, act.ph, act.ih, act.fl, act.ib,
                         act.cnt, e.fa, e.fb, e.ba, e.bb, e.ph, e.ih, e.fl, e.ib, e.cnt);
            end
            // A load sitting in MEM must never be what EX is waiting on
            checks++;
            if (dut.mem_q.ld && (dut.mem_a_hit || dut.mem_b_hit)) begin
                errors++;
                $display("FAIL mem_load_match at %s: got 1, want 0", n);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_rd = 0; id_we = 0; id_ld = 0; ex_flush = 0;
        @(posedge clk);
        #1;
        nop("reset", zz());
        rst_n = 1'b1;

        // Independent instructions
        r3("free_add", 1, 2, 3, zz());
        r3("free_sub", 4, 5, 6, zz());
        nop("free_ex_sub", zz());
        drain();

        // EX->EX on both operands
        r3("exex_add", 1, 2, 3, zz());
        r3("exex_or", 3, 3, 4, zz());
        nop("exex_fwd", mk(1, 1, 0, 0, 0, 0, 0, 0));
        drain();

        // Two apart: from WB
        r3("two_add", 1, 2, 3, zz());
        nop("two_gap", zz());
        r3("two_and", 3, 1, 5, zz());
        nop("two_fwd_wb", mk(2, 0, 0, 0, 0, 0, 0, 0));
        drain();

        // Two producers of $3: MEM beats WB
        r3("prio_add1", 1, 2, 3, zz());
        r3("prio_add2", 7, 8, 3, zz());
        r3("prio_and", 3, 1, 5, zz());
        nop("prio_fwd_mem", mk(1, 0, 0, 0, 0, 0, 0, 0));
        drain();

        // ID read while producer writes back
        r3("byp_add", 1, 2, 3, zz());
        nop("byp_gap1", zz());
        nop("byp_gap2", zz());
        r3("byp_sub", 3, 3, 7, mk(0, 0, 1, 1, 0, 0, 0, 0));
        nop("byp_after", zz());
        drain();

        // Writes to $0 are never bypassed
        r3("byp0_add", 1, 2, 0, zz());
        nop("byp0_gap1", zz());
        nop("byp0_gap2", zz());
        r3("byp0_sub", 0, 0, 7, zz());
        drain();

        // Load-use: one stall, then forward from WB
        lw("lu_lw", 1, 2, zz());
        r3("lu_stall", 2, 2, 4, mk(0, 0, 0, 0, 1, 1, 0, 1));
        cnt_e = 1;
        r3("lu_release", 2, 2, 4, zz());
        nop("lu_fwd_wb", mk(2, 2, 0, 0, 0, 0, 0, 0));
        drain();

        // Load into $0 never stalls
        lw("lu0_lw", 1, 0, zz());
        r3("lu0_add", 0, 0, 4, zz());
        nop("lu0_ex", zz());
        drain();

        // Load-use through rt only
        lw("lurt_lw", 1, 5, zz());
        drive("lurt_stall", 1, 0, 5, 0, 1, 4, 1, 0, 0, mk(0, 0, 0, 0, 1, 1, 0, 1));
        cnt_e = 2;
        drive("lurt_release", 1, 0, 5, 0, 1, 4, 1, 0, 0, zz());
        nop("lurt_fwd_wb", mk(0, 2, 0, 0, 0, 0, 0, 0));
        drain();

        // Flush coinciding with load-use: flush only, no count
        lw("fl_lw", 1, 2, zz());
        drive("fl_flush", 1, 2, 2, 1, 1, 4, 1, 0, 1, mk(0, 0, 0, 0, 0, 0, 1, 1));
        nop("fl_after", zz());
        drain();

        // Reset mid-stream with a load-use pending and producers in flight
        r3("rst_add", 1, 1, 2, zz());
        lw("rst_lw", 1, 2, zz());
        rst_n = 1'b0;
        cnt_e = 0;
        id_valid = 1; id_rs = 2; id_rt = 2; id_uses_rs = 1; id_uses_rt = 1;
        id_rd = 4; id_we = 1; id_ld = 0; ex_flush = 0;
        exp_q.push_back(zz());
        name_q.push_back("rst_outputs");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        nop("rst_no_fwd", zz());
        drain();

        // Repeated load-use stalls until the counter saturates
        for (int i = 0; i < CMAX + 4; i++) begin
            lw("sat_lw", 1, 2, (i > 0) ? mk(2, 2, 0, 0, 0, 0, 0, 0) : zz());
            r3("sat_stall", 2, 2, 4, mk(0, 0, 0, 0, 1, 1, 0, 1));
            if (cnt_e < CMAX) cnt_e++;
            r3("sat_release", 2, 2, 4, zz());
        end
        nop("sat_last_fwd", mk(2, 2, 0, 0, 0, 0, 0, 0));
        nop("sat_hold", zz());
        drain();

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
